pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined WIDTH-bit adder/subtractor, the next generation of the team's 4-bit ripple-carry adder. The carry chain is split into STAGES equal slices, one slice per clock, with a carry register between slices, so long words close timing at full clock rate. Operands enter and results leave over valid/ready handshakes with backpressure. The block sits in datapaths that need one wide add or subtract per cycle.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth (number of slices); 1 ≤ STAGES ≤ WIDTH.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a−b (a + ~b + 1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Slice width CW = WIDTH/STAGES. Stage i adds bits [i·CW +: CW] using the carry registered by stage i−1; stage 0 uses cin, or 1 when sub=1.
- On accept, B is inverted if sub=1 before entering stage 0; the sub flag is not carried further.
- Operand bits for later slices travel down the pipe in skew registers. Completed lower sum bits travel alongside until the last stage.
- Each stage holds a valid bit. Bubbles propagate; no beat is dropped or duplicated.
- Global advance: advance = !out_valid || out_ready. in_ready = advance (combinational from out_ready and out_valid). When advance=0, every stage register holds.
- Accept occurs when in_valid && in_ready. If in_valid=0 while advance=1, a bubble enters.
- ovf uses the MSB carry-in registered inside the last slice.
- Reset (rst_n=0 at an edge): all valid bits clear, so in-flight beats are discarded. Also sum=0, cout=0, ovf=0, out_valid=0. in_ready=1 in the first cycle after reset.
- Data registers load only on advance, so sum/cout/ovf stay stable while out_valid=1 and out_ready=0.

## Timing
- Latency: a beat accepted at edge k presents out_valid=1 with its result after edge k+STAGES−1 when there is no stall. STAGES=1 gives a single registered adder.
- Throughput: one beat per cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 freezes all stages. in_ready drops in the same cycle. The cycle out_ready rises, the output beat retires and a new beat can be accepted in that same cycle.
- Simultaneous retire and accept with a full pipe is legal, and occupancy is unchanged.
- Wrap-around: sum is truncated to WIDTH; the lost bit appears only in cout.

## Structure
- Package pipelined_adder_pkg holds a function computing CW. It also holds an elaboration check that WIDTH % STAGES == 0 and STAGES ≤ WIDTH.
- Sub-module adder_stage: one CW-bit slice. It contains the combinational slice add, the carry register, the valid bit, and the skew/sum pass-through registers. It is instantiated STAGES times through a generate loop.
- Top level contains only the advance/handshake logic, B inversion and output assignment.

## Test plan
- WIDTH=16, STAGES=4: a=0x1234, b=0x4321, cin=0, sub=0 → sum=0x5555, cout=0, ovf=0, with out_valid exactly 4 cycles after accept.
- Carry across all slices: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1.
- Backpressure: stream 8 beats (a=i, b=i) with out_ready=0 for cycles 3–7. in_ready must be low whenever out_valid=1 and out_ready=0. Results must be 2i in order with none lost, and sum stable while stalled.
- Reset mid-stream: assert rst_n=0 for one edge with 3 beats in flight → out_valid=0, sum=0, in_ready=1 next cycle, and no stale result ever emerges.
- Randomised sweep for STAGES ∈ {1,2,4,16} against a reference model, with random in_valid/out_ready.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - shared constants and configuration helpers for the pipelined adder
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Legal configurations split the word into equal, non-empty slices.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result handshake bundle for the pipelined adder
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/adder_stage.sv
// rtl/adder_stage.sv - one CW-bit carry slice with its carry, valid, skew and partial-sum registers
module adder_stage
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int IDX    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             valid_in,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] sum_in,
    output logic             valid_out,
    output logic             carry_out,
    output logic             ovf_out,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] sum_out
);
    localparam int CW  = slice_width(WIDTH, STAGES);
    localparam int LSB = IDX * CW;

    logic [CW:0]      slice_add;
    logic             msb_cin;
    logic             valid_d, valid_q;
    logic             carry_d, carry_q;
    logic             msb_cin_d, msb_cin_q;
    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;
    logic [WIDTH-1:0] sum_d, sum_q;

    always_comb begin
        slice_add = {1'b0, a_in[LSB +: CW]} + {1'b0, b_in[LSB +: CW]} + {{CW{1'b0}}, carry_in};
        // Carry into the slice's top bit, recovered from its sum bit.
        msb_cin   = a_in[LSB+CW-1] ^ b_in[LSB+CW-1] ^ slice_add[CW-1];
        valid_d   = valid_q;
        carry_d   = carry_q;
        msb_cin_d = msb_cin_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        if (advance) begin
            valid_d   = valid_in;
            carry_d   = slice_add[CW];
            msb_cin_d = msb_cin;
            a_d       = a_in;
            b_d       = b_in;
            sum_d     = sum_in | (WIDTH'(slice_add[CW-1:0]) << LSB);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            carry_q   <= carry_d;
            msb_cin_q <= msb_cin_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
        end
    end

    assign valid_out = valid_q;
    assign carry_out = carry_q;
    assign ovf_out   = msb_cin_q ^ carry_q;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign sum_out   = sum_q;

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep pipelined WIDTH-bit adder/subtractor with valid/ready flow control
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_adder_if.slave  bus
);
    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES <= WIDTH");
    end

    logic             advance;
    logic             valid_w [0:STAGES];
    logic             carry_w [0:STAGES];
    logic [WIDTH-1:0] a_w     [0:STAGES];
    logic [WIDTH-1:0] b_w     [0:STAGES];
    logic [WIDTH-1:0] sum_w   [0:STAGES];
    logic [STAGES-1:0] ovf_w;
    logic             unused_pipe;

    // One global enable: the whole pipe moves unless the output beat is blocked.
    always_comb begin
        advance = !valid_w[STAGES] || bus.out_ready;
    end

    assign bus.in_ready = advance;

    assign valid_w[0] = bus.in_valid;
    assign carry_w[0] = bus.sub ? 1'b1 : bus.cin;
    assign a_w[0]     = bus.a;
    assign b_w[0]     = bus.sub ? ~bus.b : bus.b;
    assign sum_w[0]   = '0;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        adder_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .IDX    (i)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance   (advance),
            .valid_in  (valid_w[i]),
            .carry_in  (carry_w[i]),
            .a_in      (a_w[i]),
            .b_in      (b_w[i]),
            .sum_in    (sum_w[i]),
            .valid_out (valid_w[i+1]),
            .carry_out (carry_w[i+1]),
            .ovf_out   (ovf_w[i]),
            .a_out     (a_w[i+1]),
            .b_out     (b_w[i+1]),
            .sum_out   (sum_w[i+1])
        );
    end

    assign bus.out_valid = valid_w[STAGES];
    assign bus.sum       = sum_w[STAGES];
    assign bus.cout      = carry_w[STAGES];
    assign bus.ovf       = ovf_w[STAGES-1];

    // Skew operands leaving the last slice and earlier-slice overflow flags have no consumer.
    assign unused_pipe = ^{a_w[STAGES], b_w[STAGES], ovf_w};

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder at STAGES 1, 2, 4 and 16
module tb_pipelined_adder;

    localparam int W    = 16;
    localparam int NDUT = 4;
    localparam int D4   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          cin = 1'b0;
    logic          sub = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;

    logic [NDUT-1:0] ov, ir, co, of;
    logic [W-1:0]    sm [NDUT];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [17:0] expq [NDUT][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int STG = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
        pipelined_adder_if #(.WIDTH(W)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.a         = a_in;
        assign bus.b         = b_in;
        assign bus.cin       = cin;
        assign bus.sub       = sub;
        assign bus.out_ready = out_ready;
        pipelined_adder #(.WIDTH(W), .STAGES(STG)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign ov[g] = bus.out_valid;
        assign ir[g] = bus.in_ready;
        assign co[g] = bus.cout;
        assign of[g] = bus.ovf;
        assign sm[g] = bus.sum;
    end

    // Arithmetic reference: {ovf, cout, sum} from integer add/subtract and sign rules.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic s);
        int unsigned ai, bi, r;
        logic        cy, vf;
        logic [15:0] res;
        ai = a;
        bi = b;
        if (s) begin
            r  = ai + 32'd65536 - bi;
            cy = (ai >= bi);
        end else begin
            r  = ai + bi + (c ? 32'd1 : 32'd0);
            cy = (r > 32'd65535);
        end
        res = r[15:0];
        if (s) vf = (a[15] != b[15]) && (res[15] != a[15]);
        else   vf = (a[15] == b[15]) && (res[15] != a[15]);
        return {vf, cy, res};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic c,
                           input logic s, input logic [15:0] es, input logic ec,
                           input logic eo, input string tag);
        int lat;
        @(negedge clk);
        a_in = a; b_in = b; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, " in_ready"}, 32'(ir[D4]), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!ov[D4] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 32'd4);
        check({tag, " sum"}, 32'(sm[D4]), 32'(es));
        check({tag, " cout"}, 32'(co[D4]), 32'(ec));
        check({tag, " ovf"}, 32'(of[D4]), 32'(eo));
    endtask

    initial begin : main
        int          c, nin, nout, stale;
        logic        stall_prev;
        logic [15:0] prev_sum;
        logic [17:0] exp;
        logic [15:0] corner [4];

        corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h7FFF; corner[3] = 16'h8000;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset out_valid", 32'(ov), 32'd0);
        check("reset in_ready", 32'(ir), 32'hF);
        check("reset sum", 32'(sm[D4]), 32'd0);
        check("reset cout", 32'(co[D4]), 32'd0);
        check("reset ovf", 32'(of[D4]), 32'd0);

        // Directed arithmetic
        run_one(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add basic");
        run_one(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "carry chain");
        run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add ovf");
        run_one(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub borrow");
        run_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub ovf");
        run_one(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, "sub cin ignored");

        // Backpressure: 8 beats, output blocked for cycles 3..7
        c = 0; nin = 0; nout = 0; stall_prev = 1'b0; prev_sum = '0;
        while (nout < 8 && c < 60) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 7);
            in_valid  = (nin < 8);
            a_in = 16'(nin); b_in = 16'(nin); cin = 1'b0; sub = 1'b0;
            #1;
            if (ov[D4] && !out_ready) begin
                check("bp in_ready low", 32'(ir[D4]), 32'd0);
                if (stall_prev) check("bp sum stable", 32'(sm[D4]), 32'(prev_sum));
            end
            stall_prev = ov[D4] && !out_ready;
            prev_sum   = sm[D4];
            if (ov[D4] && out_ready) begin
                check("bp result", 32'(sm[D4]), 32'(2 * nout));
                nout++;
            end
            if (in_valid && ir[D4]) nin++;
            c++;
        end
        check("bp beats out", nout, 32'd8);
        in_valid = 1'b0;

        // Reset with three beats in flight
        repeat (10) @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a_in = 16'($urandom); b_in = 16'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst out_valid", 32'(ov), 32'd0);
        check("midrst sum", 32'(sm[D4]), 32'd0);
        check("midrst in_ready", 32'(ir[D4]), 32'd1);
        stale = 0;
        repeat (20) begin
            @(negedge clk);
            if (ov != '0) stale++;
        end
        check("midrst no stale", stale, 32'd0);

        // Randomised sweep across all four pipeline depths
        for (int k = 0; k < NDUT; k++) expq[k].delete();
        for (int cyc = 0; cyc < 3040; cyc++) begin
            @(negedge clk);
            if (cyc < 3000) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 7);
                a_in = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
                b_in = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
                cin  = 1'($urandom);
                sub  = 1'($urandom);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            for (int k = 0; k < NDUT; k++) begin
                check($sformatf("sweep in_ready d%0d", k), 32'(ir[k]), 32'(!ov[k] || out_ready));
                if (ov[k] && out_ready) begin
                    if (expq[k].size() == 0) begin
                        check($sformatf("sweep spurious d%0d", k), 32'(ov[k]), 32'd0);
                    end else begin
                        exp = expq[k].pop_front();
                        check($sformatf("sweep result d%0d", k), 32'({of[k], co[k], sm[k]}), 32'(exp));
                    end
                end
                if (in_valid && ir[k]) expq[k].push_back(model(a_in, b_in, cin, sub));
            end
        end
        for (int k = 0; k < NDUT; k++)
            check($sformatf("sweep drained d%0d", k), expq[k].size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
